// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Producer side of the instruction-register load interface. Holds the
//   program counter, issues word reads to instruction memory with a
//   request/ready handshake, captures the returned word and presents it on
//   mdat with a one-cycle ldir strobe.
//
//   Optional feature macro: FETCH_PARITY_EN
//     defined     -> even parity of {mem_rdata, mem_par} is checked on every
//                    returned word; a bad word sets fetch_err and is dropped.
//     not defined -> mem_par is ignored, no parity logic.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   fetch_en            level request to start a fetch from IDLE
//   jump, jump_addr     load pc from jump_addr (aborts an outstanding read)
//   err_clr             clears the sticky fetch_err flag
//   mem_rd, mem_addr    memory read request / address (mem_addr == pc)
//   mem_rdata, mem_ready, mem_par   memory response and its parity bit
//   mdat, ldir          captured instruction word and its load strobe
//   pc                  current program counter
//   busy                high whenever the unit is not IDLE
//   fetch_err           sticky error (timeout or parity)
module instruction_fetch_unit #(
    parameter int AW       = 13,
    parameter int DW       = 16,
    parameter int PC_RESET = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_en,
    input  logic          jump,
    input  logic [AW-1:0] jump_addr,
    input  logic          err_clr,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    input  logic          mem_par,
    output logic [DW-1:0] mdat,
    output logic          ldir,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          fetch_err
);

    typedef enum logic [1:0] {IDLE, REQ, LOAD} state_t;

    // REQ cycle k (1-based) sees cnt == k-1, so the abort fires on the
    // TIMEOUT-th cycle without mem_ready.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt;
    logic       cap, err_set, cnt_clr, cnt_inc, par_ok;

`ifdef FETCH_PARITY_EN
    assign par_ok = ~(^{mem_rdata, mem_par});
`else
    logic unused_par;
    assign unused_par = mem_par;
    assign par_ok     = 1'b1;
`endif

    assign mem_addr = pc;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_rd    = 1'b0;
        ldir      = 1'b0;
        cap       = 1'b0;
        err_set   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                // a jump in the same cycle only loads pc; fetch starts later
                if (fetch_en && !jump) state_nxt = REQ;
            end
            REQ: begin
                mem_rd = 1'b1;
                if (jump) begin
                    // abort; any same-cycle response is discarded
                    state_nxt = IDLE;
                end else if (mem_ready) begin
                    if (par_ok) begin
                        cap       = 1'b1;
                        state_nxt = LOAD;
                    end else begin
                        err_set   = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (cnt == TO_LAST) begin
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            LOAD: begin
                ldir      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= AW'(PC_RESET);
            mdat      <= '0;
            cnt       <= '0;
            fetch_err <= 1'b0;
        end else begin
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 8'd1;

            if (jump)     pc <= jump_addr;
            else if (cap) pc <= pc + AW'(1);

            if (cap) mdat <= mem_rdata;

            // set wins over a simultaneous clear
            if (err_set)      fetch_err <= 1'b1;
            else if (err_clr) fetch_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, fetch_en, jump, err_clr, mem_ready, mem_par;
    logic [12:0] jump_addr;
    logic [15:0] mem_rdata;
    logic        mem_rd, ldir, busy, fetch_err;
    logic [12:0] mem_addr, pc;
    logic [15:0] mdat;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [15:0] d;
        logic [12:0] pc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    instruction_fetch_unit #(.AW(13), .DW(16), .PC_RESET(0), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .jump(jump),
        .jump_addr(jump_addr), .err_clr(err_clr), .mem_rd(mem_rd),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_par(mem_par), .mdat(mdat), .ldir(ldir), .pc(pc), .busy(busy),
        .fetch_err(fetch_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // monitor: every ldir pulse must match the next queued expectation
    always @(negedge clk) begin
        if (!rst && ldir) begin
            if (sb.size() == 0) begin
                chk("unexpected_ldir", {16'h0, mdat}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ldir_mdat", {16'h0, mdat}, {16'h0, e.d});
                chk("ldir_pc", {19'h0, pc}, {19'h0, e.pc});
            end
        end
    end

    initial begin
        int n;
        logic good_par;
        exp_t e;
        rst = 1; fetch_en = 0; jump = 0; jump_addr = '0; err_clr = 0;
        mem_ready = 0; mem_par = 0; mem_rdata = '0;
        step(); step();
        rst = 0;
        chk("rst_pc", {19'h0, pc}, 32'h0);
        chk("rst_mdat", {16'h0, mdat}, 32'h0);
        chk("rst_ldir", {31'h0, ldir}, 32'h0);
        chk("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_err", {31'h0, fetch_err}, 32'h0);

        // zero-wait fetch at address 0
        fetch_en = 1; mem_ready = 1; mem_rdata = 16'hA5C3;
        e.d = 16'hA5C3; e.pc = 13'd1; sb.push_back(e);
        step();
        fetch_en = 0;
        chk("t1_mem_rd", {31'h0, mem_rd}, 32'h1);
        chk("t1_addr", {19'h0, mem_addr}, 32'h0);
        step();
        mem_ready = 0;
        chk("t1_ldir", {31'h0, ldir}, 32'h1);
        step();
        chk("t1_pc", {19'h0, pc}, 32'h1);
        chk("t1_busy", {31'h0, busy}, 32'h0);

        // ready delayed 3 cycles
        fetch_en = 1; mem_rdata = 16'h1234;
        e.d = 16'h1234; e.pc = 13'd2; sb.push_back(e);
        step();
        fetch_en = 0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_mem_rd_wait", {31'h0, mem_rd}, 32'h1);
            chk("t2_addr_wait", {19'h0, mem_addr}, 32'h1);
            step();
        end
        chk("t2_mem_rd_4th", {31'h0, mem_rd}, 32'h1);
        mem_ready = 1;
        step();
        mem_ready = 0;
        chk("t2_load_rd_low", {31'h0, mem_rd}, 32'h0);
        step();
        chk("t2_pc", {19'h0, pc}, 32'h2);

        // timeout
        fetch_en = 1;
        step();
        fetch_en = 0;
        n = 0;
        while (mem_rd && n < 40) begin
            n++;
            step();
        end
        chk("t3_req_cycles", n, 32'd15);
        chk("t3_err", {31'h0, fetch_err}, 32'h1);
        chk("t3_busy", {31'h0, busy}, 32'h0);
        chk("t3_pc", {19'h0, pc}, 32'h2);
        err_clr = 1;
        step();
        err_clr = 0;
        chk("t3_err_clr", {31'h0, fetch_err}, 32'h0);

        // jump in REQ with same-cycle ready: response discarded
        fetch_en = 1;
        step();
        fetch_en = 0;
        mem_ready = 1; mem_rdata = 16'hBEEF; jump = 1; jump_addr = 13'h1FFF;
        step();
        jump = 0; mem_ready = 0;
        chk("t4_pc", {19'h0, pc}, 32'h1FFF);
        chk("t4_busy", {31'h0, busy}, 32'h0);
        chk("t4_mem_rd", {31'h0, mem_rd}, 32'h0);
        step();
        fetch_en = 1; mem_ready = 1; mem_rdata = 16'hC0DE;
        e.d = 16'hC0DE; e.pc = 13'd0; sb.push_back(e);
        step();
        fetch_en = 0;
        chk("t4_addr_top", {19'h0, mem_addr}, 32'h1FFF);
        step();
        mem_ready = 0;
        step();
        chk("t4_pc_wrap", {19'h0, pc}, 32'h0);

        // jump during LOAD: strobe still completes
        fetch_en = 1; mem_ready = 1; mem_rdata = 16'h5A5A;
        e.d = 16'h5A5A; e.pc = 13'd1; sb.push_back(e);
        step();
        fetch_en = 0;
        step();
        mem_ready = 0; jump = 1; jump_addr = 13'h0100;
        step();
        jump = 0;
        chk("t5_pc", {19'h0, pc}, 32'h100);

        // reset mid-REQ
        fetch_en = 1;
        step();
        fetch_en = 0; rst = 1;
        step();
        chk("t6_mem_rd", {31'h0, mem_rd}, 32'h0);
        chk("t6_ldir", {31'h0, ldir}, 32'h0);
        chk("t6_pc", {19'h0, pc}, 32'h0);
        chk("t6_mdat", {16'h0, mdat}, 32'h0);
        rst = 0;
        step();

`ifdef FETCH_PARITY_EN
        // bad parity: dropped with error
        fetch_en = 1; mem_ready = 1; mem_rdata = 16'h0001; mem_par = 0;
        step();
        fetch_en = 0;
        step();
        mem_ready = 0;
        chk("t7_par_err", {31'h0, fetch_err}, 32'h1);
        chk("t7_pc", {19'h0, pc}, 32'h0);
        chk("t7_busy", {31'h0, busy}, 32'h0);
        step();
        good_par = 1'b1;
`else
        // parity bit ignored: even a "bad" bit loads normally
        good_par = 1'b0;
`endif
        fetch_en = 1; mem_ready = 1; mem_rdata = 16'h0001; mem_par = good_par;
        e.d = 16'h0001; e.pc = 13'd1; sb.push_back(e);
        step();
        fetch_en = 0;
        step();
        mem_ready = 0;
        step();
        chk("t7_pc_load", {19'h0, pc}, 32'h1);

        step(); step();
        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Producer side of the instruction-register load interface. Holds the program counter, issues word reads to instruction memory with a request/ready handshake, and captures the returned word.
- Presents the word on mdat with a one-cycle ldir strobe to the instruction register.
- Sits between the instruction memory and the instruction register. Driven by the control FSM through fetch_en and jump.

Parameters:
- AW, 13, program counter / memory address width (matches the 13-bit address field of the instruction word).
- DW, 16, instruction word width.
- PC_RESET, 0, program counter value after reset.
- TIMEOUT, 15, maximum cycles spent in REQ waiting for mem_ready before abort (1..255).

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- fetch_en  input  1  level request: start a fetch when in IDLE.
- jump  input  1  load PC from jump_addr.
- jump_addr  input  AW  jump target.
- err_clr  input  1  clears fetch_err.
- mem_rd  output  1  memory read request.
- mem_addr  output  AW  memory read address (equals pc while mem_rd=1).
- mem_rdata  input  DW  memory read data, valid when mem_ready=1.
- mem_ready  input  1  memory read data valid.
- mem_par  input  1  even-parity bit of mem_rdata (used only with FETCH_PARITY_EN).
- mdat  output  DW  registered instruction word to the instruction register.
- ldir  output  1  one-cycle load strobe; mdat is valid while ldir=1.
- pc  output  AW  current program counter.
- busy  output  1  high in any state other than IDLE.
- fetch_err  output  1  sticky error flag.

Behaviour:
- Reset (rst=1 at clk edge, overrides everything, including mid-transaction):
  - state=IDLE, pc=PC_RESET, mdat=0, ldir=0, mem_rd=0, fetch_err=0, timeout counter=0.
- States:
  - IDLE: fetch_en=1 -> REQ. Timeout counter cleared.
  - REQ: mem_rd=1, mem_addr=pc.
    - mem_ready=1: mdat<=mem_rdata, pc<=pc+1 (mod 2^AW, wraps all-ones -> 0), -> LOAD.
    - Otherwise the counter increments. When the counter reaches TIMEOUT: fetch_err<=1, -> IDLE, pc and mdat unchanged.
  - LOAD: ldir=1 for exactly this cycle, mdat stable. Next state is always IDLE, so back-to-back fetches cost 3 cycles per word (IDLE, REQ with ready, LOAD).
- Latency: fetch_en high in IDLE with zero-wait memory -> mem_rd in cycle 1, ldir in cycle 2.
- mem_addr is driven with pc in all states. mem_rd=0 outside REQ.
- jump (highest priority after rst, any state): pc<=jump_addr next edge.
  - In REQ: the request is aborted (mem_rd drops next cycle), the response is discarded even if mem_ready=1 in the same cycle, -> IDLE, ldir not pulsed.
  - In LOAD: the ldir pulse still completes with the already-captured mdat.
  - jump with fetch_en in IDLE: pc loads and state stays IDLE. The fetch starts the following cycle if fetch_en is still high.
- mem_ready outside REQ is ignored.
- fetch_err is sticky until err_clr=1 or rst. err_clr and a new error in the same cycle -> fetch_err=1 (set wins). fetch_err does not block further fetches.

Optional Feature:
- FETCH_PARITY_EN defined:
  - In REQ with mem_ready=1, even parity of {mem_rdata, mem_par} is checked. On mismatch: fetch_err<=1, mdat and pc unchanged, -> IDLE, no ldir.
- Not defined: mem_par is ignored and no parity logic is synthesized.

Test Plan:
- Reset then fetch_en=1, memory answers same cycle with 16'hA5C3 at address 0 -> mem_rd=1 with mem_addr=0 in cycle 1; ldir=1 with mdat=16'hA5C3 in cycle 2; pc=1 afterwards.
- mem_ready delayed 3 cycles -> mem_rd held 4 cycles with stable mem_addr, single ldir pulse, pc increments exactly once.
- No mem_ready for TIMEOUT=15 cycles -> fetch_err=1, busy=0, pc unchanged; err_clr pulse -> fetch_err=0.
- jump with jump_addr=13'h1FFF in REQ with mem_ready=1 in the same cycle -> no ldir, pc=13'h1FFF. The next fetch reads 13'h1FFF, then pc wraps to 0.
- rst asserted during REQ -> next cycle mem_rd=0, ldir=0, pc=PC_RESET, mdat=0.
- FETCH_PARITY_EN defined, mem_rdata=16'h0001 with mem_par=0 -> fetch_err=1, no ldir, pc unchanged. Same data with mem_par=1 -> normal load.
